int_ctrl: RTL

INT_CTRL -- requirements
Module: int_ctrl

---
 rtl/int_ctrl_if.sv | 27 ++
 rtl/int_ctrl.sv | 115 +++++++++++
 2 files changed

// File: rtl/int_ctrl_if.sv
// Bus between the CPU core and the interrupt controller: raw lines and
// CPU-side controls in, request/cause/EPC and status out.
interface int_ctrl_if;
   logic [4:0]  irq_in;
   logic        ie;
   logic        mask_we;
   logic [4:0]  mask_wdata;
   logic        int_ack;
   logic        eret;
   logic [31:0] pc_in;
   logic        int_req;
   logic [2:0]  int_cause;
   logic [31:0] epc;
   logic [4:0]  mask;
   logic [4:0]  pending;
   logic        in_service;

   modport master (
      output irq_in, ie, mask_we, mask_wdata, int_ack, eret, pc_in,
      input  int_req, int_cause, epc, mask, pending, in_service
   );

   modport slave (
      input  irq_in, ie, mask_we, mask_wdata, int_ack, eret, pc_in,
      output int_req, int_cause, epc, mask, pending, in_service
   );
endinterface

// File: rtl/int_ctrl.sv
// Five-line interrupt controller: synchronizes external lines, tracks pending
// sources, arbitrates with fixed priority and runs a single-level handshake.
module int_ctrl #(
   parameter int         SYNC_STAGES = 2,
   parameter logic [4:0] EDGE_MASK   = 5'b00000
) (
   input logic        clk,
   input logic        rst,
   int_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

   state_t      state;
   logic [4:0]  sync_chain [SYNC_STAGES];
   logic [4:0]  sync_now;
   logic [4:0]  sync_prev;
   logic [4:0]  pending_r;
   logic [4:0]  mask_r;
   logic [4:0]  eligible;
   logic [4:0]  rise;
   logic [4:0]  ack_clr;
   logic [2:0]  winner;
   logic [2:0]  cause_r;
   logic        int_req_r;
   logic        in_service_r;
   logic [31:0] epc_r;

   assign sync_now = sync_chain[SYNC_STAGES-1];
   assign rise     = sync_now & ~sync_prev;
   assign eligible = pending_r & mask_r & {5{bus.ie}};

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_chain[k] <= '0;
         sync_prev <= '0;
      end else begin
         sync_chain[0] <= bus.irq_in;
         for (int k = 1; k < SYNC_STAGES; k++) sync_chain[k] <= sync_chain[k-1];
         sync_prev <= sync_now;
      end
   end

   // Only an acknowledge of the source currently being requested clears it.
   always_comb begin
      ack_clr = '0;
      if (state == REQ && bus.int_ack) ack_clr[cause_r] = 1'b1;
   end

   always_comb begin
      winner = '0;
      for (int i = 4; i >= 0; i--) begin
         if (eligible[i]) winner = 3'(i);
      end
   end

   // Edge lines are sticky with set taking precedence; level lines follow sync.
   always_ff @(posedge clk) begin
      if (rst) begin
         pending_r <= '0;
         mask_r    <= '0;
      end else begin
         pending_r <= (EDGE_MASK & ((pending_r & ~ack_clr) | rise)) |
                      (~EDGE_MASK & sync_now);
         if (bus.mask_we) mask_r <= bus.mask_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         int_req_r    <= 1'b0;
         in_service_r <= 1'b0;
         cause_r      <= '0;
         epc_r        <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (eligible != 5'b0) begin
                  state     <= REQ;
                  int_req_r <= 1'b1;
                  cause_r   <= winner;
               end
            end
            REQ: begin
               if (bus.int_ack) begin
                  state        <= SERVICE;
                  int_req_r    <= 1'b0;
                  in_service_r <= 1'b1;
                  epc_r        <= bus.pc_in;
               end
            end
            SERVICE: begin
               if (bus.eret) begin
                  state        <= IDLE;
                  in_service_r <= 1'b0;
               end
            end
            default: begin
               state        <= IDLE;
               int_req_r    <= 1'b0;
               in_service_r <= 1'b0;
            end
         endcase
      end
   end

   assign bus.int_req    = int_req_r;
   assign bus.int_cause  = cause_r;
   assign bus.epc        = epc_r;
   assign bus.mask       = mask_r;
   assign bus.pending    = pending_r;
   assign bus.in_service = in_service_r;

endmodule
